// File: rtl/sd_seq_check.sv
// Consumer-side srdy/drdy sequence checker for incrementing {tag, count} traffic.
// Optional feature macro: SD_SEQ_CHECK_RESYNC_EN (resync expected count to the stream on a bad word).
module sd_seq_check #(
    parameter int                  width    = 8,
    parameter int                  tag_sz   = 1,
    parameter logic [tag_sz-1:0]   tag_val  = '0,
    parameter int                  pat_dep  = 8,
    parameter logic [pat_dep-1:0]  drdy_pat = '1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             c_srdy,
    output logic             c_drdy,
    input  logic [width-1:0] c_data,
    input  logic             start,
    input  logic [31:0]      amount,
    input  logic             clear,
    output logic             done,
    output logic             err,
    output logic [15:0]      ok_count,
    output logic [15:0]      err_count,
    output logic [width-1:0] last_bad
);

    localparam int count_sz = width - tag_sz;
    localparam int ptr_w    = (pat_dep > 1) ? $clog2(pat_dep) : 1;

    localparam logic [1:0] s_idle = 2'd0;
    localparam logic [1:0] s_run  = 2'd1;
    localparam logic [1:0] s_done = 2'd2;

    logic [1:0]          state, state_n;
    logic [ptr_w-1:0]    ptr, ptr_n;
    logic [31:0]         remaining, remaining_n;
    logic [count_sz-1:0] expected;
    logic                xfer;
    logic                good;
    logic [tag_sz-1:0]   rx_tag;
    logic [count_sz-1:0] rx_cnt;

    assign xfer   = c_srdy & c_drdy;
    assign rx_tag = c_data[width-1 -: tag_sz];
    assign rx_cnt = c_data[count_sz-1:0];
    assign good   = (rx_tag == tag_val) && (rx_cnt == expected);

    // Next run state, remaining word budget and pattern step.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        ptr_n       = ptr;
        case (state)
            s_idle, s_done: begin
                if (start) begin
                    state_n     = s_run;
                    remaining_n = amount;
                end
            end
            s_run: begin
                if (xfer && remaining != 32'd0) begin
                    remaining_n = remaining - 32'd1;
                    if (remaining == 32'd1) state_n = s_done;
                end
            end
            default: state_n = s_idle;
        endcase
        if (state == s_run) begin
            if (ptr == ptr_w'(pat_dep - 1)) ptr_n = '0;
            else                            ptr_n = ptr + 1'b1;
        end
    end

    // Run control registers; c_drdy is precomputed for the coming cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= s_idle;
            ptr       <= '0;
            remaining <= '0;
            c_drdy    <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            remaining <= remaining_n;
            c_drdy    <= (state_n == s_run) & drdy_pat[ptr_n];
            done      <= (state_n == s_done);
        end
    end

    // Word checking, counters and mismatch capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            expected  <= '0;
            err       <= 1'b0;
            ok_count  <= '0;
            err_count <= '0;
            last_bad  <= '0;
        end else if (clear) begin
            expected  <= '0;
            err       <= 1'b0;
            ok_count  <= '0;
            err_count <= '0;
            last_bad  <= '0;
        end else if (xfer) begin
            if (good) begin
                expected <= expected + 1'b1;
                if (ok_count != 16'hFFFF) ok_count <= ok_count + 16'd1;
            end else begin
                err      <= 1'b1;
                last_bad <= c_data;
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
`ifdef SD_SEQ_CHECK_RESYNC_EN
                expected <= rx_cnt + 1'b1;
`else
                expected <= expected + 1'b1;
`endif
            end
        end
    end

endmodule

// File: tb/tb_sd_seq_check.sv
// Randomized bench for sd_seq_check with a cycle-level reference model.
// Model is pinned by a few hand-computed literal checks.
module tb_sd_seq_check;

    localparam logic [7:0] PAT = 8'b1011_1101;
    localparam int         DEP = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        c_srdy = 1'b0;
    logic        c_drdy;
    logic [7:0]  c_data = '0;
    logic        start = 1'b0;
    logic [31:0] amount = '0;
    logic        clear = 1'b0;
    logic        done;
    logic        err;
    logic [15:0] ok_count;
    logic [15:0] err_count;
    logic [7:0]  last_bad;

    int errors = 0;
    int checks = 0;

    sd_seq_check #(
        .width(8), .tag_sz(1), .tag_val(1'b0),
        .pat_dep(DEP), .drdy_pat(PAT)
    ) dut (
        .clk(clk), .reset(reset),
        .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
        .start(start), .amount(amount), .clear(clear),
        .done(done), .err(err),
        .ok_count(ok_count), .err_count(err_count),
        .last_bad(last_bad)
    );

    always #5 clk = ~clk;

    // Reference model: current-cycle view of the checker.
    bit          m_run, m_done, m_err;
    int unsigned m_rem;
    int          m_step;
    logic [6:0]  m_exp;
    int          m_ok, m_ec;
    logic [7:0]  m_last;

    function automatic bit m_rdy();
        return m_run && PAT[m_step];
    endfunction

    // Advance the model at each clock edge from the inputs seen there.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_run = 0; m_done = 0; m_err = 0; m_rem = 0; m_step = 0;
            m_exp = '0; m_ok = 0; m_ec = 0; m_last = '0;
        end else begin
            bit xf;
            xf = c_srdy && m_rdy();
            if (clear) begin
                m_exp = '0; m_ok = 0; m_ec = 0; m_err = 0; m_last = '0;
            end else if (xf) begin
                if (c_data[7] == 1'b0 && c_data[6:0] == m_exp) begin
                    if (m_ok < 65535) m_ok++;
                    m_exp = m_exp + 7'd1;
                end else begin
                    m_err = 1;
                    if (m_ec < 65535) m_ec++;
                    m_last = c_data;
`ifdef SD_SEQ_CHECK_RESYNC_EN
                    m_exp = c_data[6:0] + 7'd1;
`else
                    m_exp = m_exp + 7'd1;
`endif
                end
            end
            if (m_run) begin
                m_step = (m_step + 1) % DEP;
                if (xf && m_rem != 0) begin
                    m_rem--;
                    if (m_rem == 0) begin
                        m_run = 0;
                        m_done = 1;
                    end
                end
            end else if (start) begin
                m_run = 1; m_rem = amount; m_done = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        chk("c_drdy", int'(c_drdy), int'(m_rdy()));
        chk("done", int'(done), int'(m_done));
        chk("err", int'(err), int'(m_err));
        chk("ok_count", int'(ok_count), m_ok);
        chk("err_count", int'(err_count), m_ec);
        chk("last_bad", int'(last_bad), int'(m_last));
    end

    // Producer: incrementing counter with optional injected words.
    logic [6:0] gen = '0;
    int         srdy_pct = 100;
    bit         rnd_err = 0;
    bit         inj_en = 0;
    logic [6:0] inj_at = '0;
    logic [7:0] inj_val = '0;

    task automatic drive_data();
        if (inj_en && gen == inj_at) c_data = inj_val;
        else if (rnd_err && $urandom_range(7) == 0) c_data = 8'($urandom);
        else c_data = {1'b0, gen};
    endtask

    task automatic cyc();
        logic xf;
        @(negedge clk);
        xf = c_srdy && c_drdy;
        @(posedge clk);
        #1;
        if (clear) gen = '0;
        else if (xf) gen = gen + 7'd1;
        c_srdy = ($urandom_range(99) < srdy_pct);
        drive_data();
    endtask

    task automatic run(input int amt);
        amount = amt;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc();
        clear = 1'b0;
    endtask

    task automatic wait_done(input int max);
        int n = 0;
        while (!done && n < max) begin
            cyc();
            n++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got done=%0d expected 1", done);
        end
    endtask

    initial begin
        logic [3:0] seq;
        int n;
        #12;
        chk("rst_drdy", int'(c_drdy), 0);
        chk("rst_ok", int'(ok_count), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        c_srdy = 1'b1;
        drive_data();

        // Eight incrementing words; c_drdy follows the pattern.
        run(8);
        for (int i = 0; i < 4; i++) begin
            seq[i] = c_drdy;
            cyc();
        end
        chk("drdy_seq", int'(seq), 4'b1101);
        wait_done(60);
        repeat (4) cyc();
        chk("t1_ok", int'(ok_count), 8);
        chk("t1_err", int'(err_count), 0);
        chk("t1_done", int'(done), 1);

        // 130 words: count field wraps 127 -> 0 without error.
        do_clear();
        run(130);
        wait_done(400);
        chk("t3_ok", int'(ok_count), 130);
        chk("t3_err", int'(err), 0);

        // Count 4 replaced by 5.
        do_clear();
        inj_en = 1; inj_at = 7'd4; inj_val = 8'h05;
        run(8);
        wait_done(60);
        inj_en = 0;
        chk("t4_err", int'(err), 1);
        chk("t4_last", int'(last_bad), 8'h05);
`ifndef SD_SEQ_CHECK_RESYNC_EN
        chk("t4_ok", int'(ok_count), 7);
        chk("t4_ec", int'(err_count), 1);
`endif

        // Wrong tag.
        do_clear();
        inj_en = 1; inj_at = 7'd0; inj_val = 8'h80;
        run(1);
        wait_done(20);
        inj_en = 0;
        chk("t5_ec", int'(err_count), 1);
        chk("t5_last", int'(last_bad), 8'h80);

        // Clear coincident with an accepted word in an unlimited run.
        run(0);
        n = 0;
        while (!c_drdy && n < 20) begin
            cyc();
            n++;
        end
        clear = 1'b1;
        cyc();
        clear = 1'b0;
        chk("t7_ok0", int'(ok_count), 0);
        chk("t7_ec0", int'(err_count), 0);
        repeat (10) cyc();
        chk("t7_err", int'(err), 0);
        chk("t7_done", int'(done), 0);

        // Asynchronous reset mid-run.
        do_clear();
        n = 0;
        while (ok_count < 3 && n < 40) begin
            cyc();
            n++;
        end
        chk("t6_pre", int'(ok_count), 3);
        #2;
        reset = 1'b0;
        #1;
        chk("t6_drdy", int'(c_drdy), 0);
        chk("t6_ok", int'(ok_count), 0);
        chk("t6_done", int'(done), 0);
        @(posedge clk); #1;
        reset = 1'b1;
        gen = '0;
        drive_data();

        // Randomized runs with random errors, clears and stray starts.
        rnd_err = 1;
        for (int r = 0; r < 40; r++) begin
            srdy_pct = $urandom_range(30, 100);
            clear = ($urandom_range(2) == 0);
            run($urandom_range(1, 20));
            clear = 1'b0;
            n = 0;
            while (!done && n < 400) begin
                clear = ($urandom_range(39) == 0);
                start = ($urandom_range(24) == 0);
                cyc();
                n++;
            end
            clear = 1'b0;
            start = 1'b0;
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL rnd_timeout: got done=%0d expected 1", done);
            end
            repeat ($urandom_range(0, 3)) cyc();
        end

        repeat (2) cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
